// File: rtl/ifns_13di_pkg.sv
// Shared constants, weight table and FSM state type for the 13-bit IFNS
// sequential decoder.
package ifns_13di_pkg;

    localparam int CW_W  = 18;  // codeword width (d18..d1)
    localparam int V_W   = 13;  // decoded value width
    localparam int ACC_W = 14;  // accumulator width; max sum 8361 fits
    localparam int IDX_W = 5;   // width of an absolute codeword bit index

    localparam logic [ACC_W-1:0] V_MAX = 14'd8191;

    // Weight of codeword bit i; index 0 is d1, index 17 is d18.
    localparam logic [ACC_W-1:0] IFNS_W [0:CW_W-1] = '{
        14'd1,   14'd1,   14'd2,   14'd3,   14'd5,   14'd8,
        14'd13,  14'd21,  14'd34,  14'd55,  14'd89,  14'd144,
        14'd233, 14'd377, 14'd610, 14'd987, 14'd1597, 14'd4181
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // BPC must divide the codeword evenly into whole RUN cycles.
    function automatic bit bpc_legal(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 3) ||
               (bpc == 6) || (bpc == 9) || (bpc == 18);
    endfunction

endpackage

// File: rtl/ifns_13di_decoder_seq_wsum.sv
// Combinational weight sum of a BPC-bit codeword slice. Bit j of the
// slice sits at absolute codeword index i_base + j.
module ifns_wsum
    import ifns_13di_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0]   i_slice,
    input  logic [IDX_W-1:0] i_base,
    output logic [ACC_W-1:0] o_sum
);

    // Add the weight of every set slice bit, looked up by absolute index.
    always_comb begin
        // NOTE: blocking '=' is required here; each loop pass must see the
        // running total left by the previous pass within the same evaluation.
        o_sum = '0;
        for (int i = 0; i < BPC; i++) begin
            if (i_slice[i]) begin
                o_sum = o_sum + IFNS_W[i_base + IDX_W'(i)];
            end
        end
    end

endmodule

// File: rtl/ifns_13di_decoder_seq.sv
// Sequential IFNS 13-bit decoder: accumulates codeword weights MSB-first,
// BPC bits per clock, with valid/ready on both sides.
// Optional macro IFNS_DEC_RANGE_CHECK_EN adds the err output, flagging a
// weight sum above 8191 (v then carries the sum modulo 8192).
module ifns_13di_decoder_seq
    import ifns_13di_pkg::*;
#(
    parameter int BPC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW_W-1:0] d,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [V_W-1:0]  v
`ifdef IFNS_DEC_RANGE_CHECK_EN
    ,
    output logic            err
`endif
);

    localparam int NSTEP = CW_W / BPC;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

    generate
        if (!bpc_legal(BPC)) begin : g_bad_bpc
            $error("ifns_13di_decoder_seq: BPC must be 1, 2, 3, 6, 9 or 18");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_next;
    logic [CW_W-1:0]   r_sr;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic [V_W-1:0]    r_v;
    logic [IDX_W-1:0]  w_base;
    logic [ACC_W-1:0]  w_slice_sum;
    logic [ACC_W-1:0]  w_acc_next;
    logic              w_last;

    // Original index of the slice LSB: the top BPC bits of sr on step cnt.
    assign w_base      = IDX_W'(CW_W - BPC - BPC * int'(r_cnt));
    assign w_acc_next  = r_acc + w_slice_sum;
    assign w_last      = (r_cnt == CNT_LAST);

    ifns_wsum #(
        .BPC (BPC)
    ) u_wsum (
        .i_slice (r_sr[CW_W-1 -: BPC]),
        .i_base  (w_base),
        .o_sum   (w_slice_sum)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking '<=' for all registered state, so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first, so no path leaves w_state_next
        // unassigned and no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Datapath: load the codeword, then shift and accumulate once per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_v   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sr  <= d;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_sr  <= r_sr << BPC;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_v <= w_acc_next[V_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign v = r_v;

`ifdef IFNS_DEC_RANGE_CHECK_EN
    logic r_err;

    // Range flag captured with the final sum; only visible while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_err <= (w_acc_next > V_MAX);
        end
    end

    assign err = (r_state == DONE) && r_err;
`endif

endmodule

// File: tb/tb_ifns_13di_decoder_seq.sv
// Scoreboard bench for ifns_13di_decoder_seq: three decoders (BPC 1, 3, 18)
// share the codeword bus; a monitor compares every output handshake and
// the output latency against the expected queue.
`timescale 1ns/1ps
module tb_ifns_13di_decoder_seq;

    localparam int ND = 3;
    localparam int NSTEP_A [ND] = '{18, 6, 1};
    localparam int TB_W [18] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144,
                                 233, 377, 610, 987, 1597, 4181};

    typedef struct {
        logic [12:0] v;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic [17:0] d;
    logic        in_valid  [ND];
    logic        in_ready  [ND];
    logic        out_valid [ND];
    logic [12:0] v         [ND];
`ifdef IFNS_DEC_RANGE_CHECK_EN
    logic        err       [ND];
`endif

    exp_t exp_q[$];
    int   rd       [ND];
    int   last_acc [ND];
    bit   prev_ov  [ND];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ifns_13di_decoder_seq #(.BPC(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .d(d), .out_valid(out_valid[0]), .out_ready(out_ready), .v(v[0])
`ifdef IFNS_DEC_RANGE_CHECK_EN
        , .err(err[0])
`endif
    );

    ifns_13di_decoder_seq #(.BPC(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .d(d), .out_valid(out_valid[1]), .out_ready(out_ready), .v(v[1])
`ifdef IFNS_DEC_RANGE_CHECK_EN
        , .err(err[1])
`endif
    );

    ifns_13di_decoder_seq #(.BPC(18)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .d(d), .out_valid(out_valid[2]), .out_ready(out_ready), .v(v[2])
`ifdef IFNS_DEC_RANGE_CHECK_EN
        , .err(err[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Greedy MSB-first weight selection; always exact for 0..8361.
    function automatic logic [17:0] enc(input int val);
        int          rem;
        logic [17:0] cw;
        rem = val;
        cw  = '0;
        for (int i = 17; i >= 0; i--) begin
            if (rem >= TB_W[i]) begin
                cw[i] = 1'b1;
                rem   = rem - TB_W[i];
            end
        end
        return cw;
    endfunction

    // Offer one codeword to all decoders until each has accepted it.
    task automatic send(input logic [17:0] cw, input logic [12:0] ev,
                        input logic ee, input bit push);
        bit done [ND];
        bit took [ND];
        int guard;
        if (push) exp_q.push_back('{v: ev, e: ee});
        d = cw;
        for (int k = 0; k < ND; k++) begin
            in_valid[k] = 1'b1;
            done[k]     = 1'b0;
        end
        guard = 0;
        while (!(done[0] && done[1] && done[2]) && guard < 200) begin
            @(negedge clk);
            for (int k = 0; k < ND; k++) took[k] = in_valid[k] && in_ready[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < ND; k++) begin
                if (took[k]) begin
                    in_valid[k] = 1'b0;
                    done[k]     = 1'b1;
                    last_acc[k] = cyc;
                end
            end
            guard++;
        end
        if (guard >= 200) fail_now("send_accept_timeout");
        for (int k = 0; k < ND; k++) in_valid[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!(in_ready[0] && in_ready[1] && in_ready[2]) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100) fail_now("wait_idle_timeout");
    endtask

    // Monitor: latency on each out_valid rise, value on each handshake.
    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (!rst && out_valid[k] && !prev_ov[k])
                check($sformatf("latency_dut%0d", k), cyc - last_acc[k], NSTEP_A[k]);
            if (!rst && out_valid[k] && out_ready) begin
                if (rd[k] >= exp_q.size()) begin
                    fail_now($sformatf("unexpected_output_dut%0d", k));
                end else begin
                    check($sformatf("v_dut%0d_word%0d", k, rd[k]), v[k], exp_q[rd[k]].v);
`ifdef IFNS_DEC_RANGE_CHECK_EN
                    check($sformatf("err_dut%0d_word%0d", k, rd[k]), err[k], exp_q[rd[k]].e);
`endif
                    rd[k]++;
                end
            end
            prev_ov[k] = out_valid[k];
        end
    end

    initial begin
        int prev_acc;
        int guard;
        int rv;

        rst       = 1'b1;
        out_ready = 1'b1;
        d         = '0;
        for (int k = 0; k < ND; k++) begin
            in_valid[k] = 1'b0;
            rd[k]       = 0;
            last_acc[k] = 0;
            prev_ov[k]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("rst_in_ready_dut%0d", k), in_ready[k], 1);
            check($sformatf("rst_out_valid_dut%0d", k), out_valid[k], 0);
            check($sformatf("rst_v_dut%0d", k), v[k], 0);
        end
        rst = 1'b0;

        // Directed words with hand-computed sums.
        send(18'h00000, 13'd0,    1'b0, 1'b1); wait_idle();
        send(18'h3F98F, 13'd8191, 1'b0, 1'b1); wait_idle();
        send(18'h00001, 13'd1,    1'b0, 1'b1); wait_idle();
        send(18'h00002, 13'd1,    1'b0, 1'b1); wait_idle();
        send(18'h20000, 13'd4181, 1'b0, 1'b1); wait_idle();
        send(18'h30000, 13'd5778, 1'b0, 1'b1); wait_idle();
        send(18'h3FFFF, 13'd169,  1'b1, 1'b1); wait_idle();

        // Output stall: value held, input side closed, stray in_valid ignored.
        out_ready = 1'b0;
        send(18'h20001, 13'd4182, 1'b0, 1'b1);
        guard = 0;
        while (!out_valid[0] && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) fail_now("stall_out_valid_timeout");
        d = 18'h00001;
        for (int k = 0; k < ND; k++) in_valid[k] = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < ND; k++) begin
                check($sformatf("stall_out_valid_dut%0d", k), out_valid[k], 1);
                check($sformatf("stall_v_dut%0d", k), v[k], 4182);
                check($sformatf("stall_in_ready_dut%0d", k), in_ready[k], 0);
            end
        end
        for (int k = 0; k < ND; k++) in_valid[k] = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        // Reset on RUN cycle 7 of the BPC=1 decoder: word must vanish.
        out_ready = 1'b0;
        send(18'h3F98F, 13'd0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("abort_in_ready_dut%0d", k), in_ready[k], 1);
            check($sformatf("abort_out_valid_dut%0d", k), out_valid[k], 0);
            check($sformatf("abort_v_dut%0d", k), v[k], 0);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (25) @(posedge clk);
        #1;

        // Random values through the encoder model, back to back.
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            rv = int'($urandom_range(0, 8191));
            send(enc(rv), 13'(rv), 1'b0, 1'b1);
            if (i > 0) check($sformatf("throughput_word%0d", i), last_acc[0] - prev_acc, 20);
            prev_acc = last_acc[0];
        end

        // Drain: every expected word must come out of every decoder.
        guard = 0;
        while (!(rd[0] == exp_q.size() && rd[1] == exp_q.size() &&
                 rd[2] == exp_q.size()) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 200) fail_now("drain_timeout");
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
